// File: rtl/median_pkg.sv
// Shared definitions for the 9-pixel median sequencer.
//   NUMBER      : pixels per window
//   NPASS       : max-elimination passes over the register chain
//   FINAL_STEPS : compare steps that select the median after the last pass
//   state_t     : sequencer states
//   chain_op_t  : operation applied to the register chain in a given cycle
package median_pkg;

  localparam int NUMBER      = 9;
  localparam int NPASS       = 4;
  localparam int FINAL_STEPS = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PASS,
    FINAL,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_CMP,
    OP_ROT
  } chain_op_t;

endpackage

// File: rtl/mce.sv
// Combinational compare-exchange unit (unsigned).
//   A, B : operands
//   MIN  : smaller operand
//   MAX  : larger operand (equal operands give MIN = MAX = the common value)
module mce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] MIN,
  output logic [WIDTH-1:0] MAX
);

  always_comb begin
    if (A > B) begin
      MAX = A;
      MIN = B;
    end else begin
      MAX = B;
      MIN = A;
    end
  end

endmodule

// File: rtl/median_seq.sv
// Sequential 3x3-window median: nine pixels are shifted into a register
// chain R0..R8, then a single compare-exchange unit on (R8, R7) repeatedly
// circulates the chain to discard the four largest values; the maximum of
// the five survivors is the median and ends up in R8.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   DI   : pixel data
//   DSI  : DI valid; nine consecutive valid cycles form a window
//   DO   : median of the last complete window (always equals R8)
//   DSO  : one-cycle pulse when DO holds a new median
//   BUSY : high from the first accepted pixel through the DSO cycle
//
// state | meaning
// IDLE  | waiting for the first pixel of a window
// LOAD  | shifting in pixels 2..9; a gap in DSI aborts the window
// PASS  | 4 passes of 9 steps; pass p compares 8-p times, then rotates p+1 times
// FINAL | 4 compares; R8 becomes the max of the 5 survivors (the median)
// DONE  | DSO cycle; DSI here starts the next window
module median_seq
  import median_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUMBER = 9
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             BUSY
);

  localparam logic [3:0] LOAD_LAST  = 4'(NUMBER - 1);
  localparam logic [3:0] PASS_LAST  = 4'(median_pkg::NUMBER - 1);
  localparam logic [2:0] PASS_TOP   = 3'(NPASS - 1);
  localparam logic [3:0] FINAL_LAST = 4'(FINAL_STEPS - 1);

  state_t           state, state_nx;
  logic [3:0]       step, step_nx;
  logic [2:0]       pass, pass_nx;
  chain_op_t        op;
  logic [3:0]       cmp_last;
  logic [WIDTH-1:0] r [0:8];
  logic [WIDTH-1:0] ce_min, ce_max;

  mce #(.WIDTH(WIDTH)) u_mce (
    .A   (r[8]),
    .B   (r[7]),
    .MIN (ce_min),
    .MAX (ce_max)
  );

  // Pass p compares on steps 0..7-p; the rest of the pass rotates.
  assign cmp_last = 4'd7 - {1'b0, pass};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      step  <= '0;
      pass  <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      pass  <= pass_nx;
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    pass_nx  = pass;
    op       = OP_HOLD;
    case (state)
      IDLE: begin
        if (DSI) begin
          op       = OP_LOAD;
          state_nx = LOAD;
          step_nx  = 4'd1;
          pass_nx  = '0;
        end
      end
      LOAD: begin
        if (DSI) begin
          op = OP_LOAD;
          if (step == LOAD_LAST) begin
            state_nx = PASS;
            step_nx  = '0;
            pass_nx  = '0;
          end else begin
            step_nx = step + 4'd1;
          end
        end else begin
          state_nx = IDLE;
          step_nx  = '0;
          pass_nx  = '0;
        end
      end
      PASS: begin
        op = (step <= cmp_last) ? OP_CMP : OP_ROT;
        if (step == PASS_LAST) begin
          step_nx = '0;
          if (pass == PASS_TOP) begin
            state_nx = FINAL;
            pass_nx  = '0;
          end else begin
            pass_nx = pass + 3'd1;
          end
        end else begin
          step_nx = step + 4'd1;
        end
      end
      FINAL: begin
        op = OP_CMP;
        if (step == FINAL_LAST) begin
          state_nx = DONE;
          step_nx  = '0;
        end else begin
          step_nx = step + 4'd1;
        end
      end
      DONE: begin
        if (DSI) begin
          op       = OP_LOAD;
          state_nx = LOAD;
          step_nx  = 4'd1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        step_nx  = '0;
        pass_nx  = '0;
      end
    endcase
  end

  // Compare keeps the running max in R8 and recirculates the min into R0.
  // Rotate overwrites R8 with R7, which drops the max found by the
  // preceding compares; the value pushed into R0 during a rotate lands in
  // the part of the chain that later passes never compare.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 9; i++) r[i] <= '0;
    end else begin
      case (op)
        OP_LOAD: begin
          r[0] <= DI;
          for (int i = 1; i < 9; i++) r[i] <= r[i-1];
        end
        OP_CMP: begin
          r[0] <= ce_min;
          for (int i = 1; i < 8; i++) r[i] <= r[i-1];
          r[8] <= ce_max;
        end
        OP_ROT: begin
          r[0] <= ce_min;
          for (int i = 1; i < 8; i++) r[i] <= r[i-1];
          r[8] <= r[7];
        end
        default: ;
      endcase
    end
  end

  assign DO   = r[8];
  assign DSO  = (state == DONE);
  assign BUSY = (state != IDLE);

endmodule

// File: doc/median_seq.md
MEDIAN_SEQ -- requirements
Module: median_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter NUMBER, default 9, window size; only 9 is supported.
REQ-003 SHALL have port CLK, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port DI, input, WIDTH, pixel data.
REQ-006 SHALL have port DSI, input, 1, DI valid; a window is 9 consecutive DSI-high cycles.
REQ-007 SHALL have port DO, output, WIDTH, median of the last complete window.
REQ-008 SHALL have port DSO, output, 1, one-cycle pulse when DO holds a new median.
REQ-009 SHALL have port BUSY, output, 1, high from the first accepted pixel until the DSO cycle inclusive.

Function
REQ-010 SHALL contain a 9-entry register chain R0..R8 with one compare-exchange unit on (R8, R7).
- Load: R0<=DI, Ri+1<=Ri.
- Compare: R8<=max, R0<=min.
- Rotate: R8<=R7, R0<=min.
REQ-011 SHALL implement the FSM states IDLE, LOAD, PASS, FINAL, DONE.
REQ-012 IDLE: DSI=1 SHALL capture DI into R0 and go to LOAD with the load count at 1.
REQ-013 LOAD: each DSI=1 cycle SHALL shift DI in; after the 9th pixel the FSM SHALL go to PASS with pass=0 and step=0.
REQ-014 LOAD: DSI=0 before the 9th pixel SHALL abort to IDLE, clear the counts and leave DSO low.
REQ-015 PASS p (p=0..3) SHALL last 9 cycles.
- Steps 0..7-p: compare.
- Remaining p+1 steps: rotate.
REQ-016 After pass 3 the FSM SHALL enter FINAL.
REQ-017 FINAL SHALL last 4 compare cycles, then the FSM SHALL enter DONE.
REQ-018 DONE SHALL last one cycle with DSO=1 and DO=R8 equal to the median, then return to IDLE.
REQ-019 Latency SHALL be 49 cycles from the first pixel edge to the DSO cycle: 9 load + 36 pass + 4 final.
REQ-020 DSI SHALL be ignored during PASS and FINAL; those pixels are discarded.
REQ-021 DSI=1 in the DONE cycle SHALL be accepted as pixel 1 of the next window, with the transition to LOAD.
REQ-022 DO SHALL equal R8 at all times.
REQ-023 DO SHALL hold its value after DONE until R8 is next written.
REQ-024 Comparison SHALL be unsigned over WIDTH bits.
REQ-025 Equal values SHALL give MAX=MIN=the common value.
REQ-026 The step counter SHALL be 4 bits and the pass counter 3 bits, with no wrap except by explicit clear.

Reset
REQ-027 nRST low SHALL immediately force the following: state IDLE; all counters 0; R0..R8 all 0; DO=0; DSO=0; BUSY=0.
REQ-028 Reset asserted mid-LOAD, mid-PASS or mid-FINAL SHALL discard the window with no DSO.
REQ-029 Reset deassertion SHALL take effect on the next CLK edge; the first pixel SHALL be accepted no earlier than that edge.

Structure
REQ-030 A shared package median_pkg SHALL hold the state enum type and the constants NUMBER=9, NPASS=4 and FINAL_STEPS=4.
REQ-031 Compare-exchange SHALL be a combinational sub-module mce (inputs A, B; outputs MIN, MAX), parameterised by WIDTH.
REQ-032 The sequencer and register chain SHALL reside in median_seq; no other sub-modules.

Verification
REQ-033 Load window 1,2,...,9 -> DSO pulse 49 cycles after the first pixel, DO=5.
REQ-034 Load window 9,8,...,1, then 200,0,200,0,200,0,200,0,200 back-to-back via DONE-cycle accept -> DO=5, then DO=200; two DSO pulses 49 cycles apart.
REQ-035 Load window of nine 8'hAA -> DO=8'hAA; window 255,0,255,0,0,255,0,255,128 -> DO=128.
REQ-036 DSI low after 5 pixels -> return to IDLE, BUSY=0, no DSO; a following full window 3,1,4,1,5,9,2,6,5 -> DO=4.
REQ-037 nRST low at cycle 20 of a window -> DO=0, DSO=0 and BUSY=0 immediately; no DSO until a new full window completes.
REQ-038 DSI held high through a whole computation -> only pixels 1-9 are used, and pixels arriving during PASS/FINAL are dropped.
